// File: rtl/mux_8x1_scanner_if.sv
// rtl/mux_8x1_scanner_if.sv - lane/frame bundle between the 8:1 scanner and its driver
interface mux_8x1_scanner_if;
    logic       en;
    logic       sync;
    logic [7:0] in;
    logic [2:0] s;
    logic       out;
    logic [7:0] frame;
    logic       frame_valid;

    modport master (
        output en, sync, in,
        input  s, out, frame, frame_valid
    );

    modport slave (
        input  en, sync, in,
        output s, out, frame, frame_valid
    );
endinterface

// File: rtl/mux_8x1_scanner.sv
// rtl/mux_8x1_scanner.sv - round-robin 8:1 lane scanner assembling one 8-bit frame per sweep
module mux_8x1_scanner #(
    parameter int HOLD_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rst,
    mux_8x1_scanner_if.slave   bus
);
    localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(HOLD_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    s_q, s_d;
    logic          out_q, out_d;
    logic [7:0]    asm_q, asm_d;
    logic [7:0]    frame_q, frame_d;
    logic          fv_q, fv_d;
    logic          last_dwell;

    assign last_dwell = bus.en && (cnt_q == LAST);

    always_comb begin
        cnt_d   = cnt_q;
        s_d     = s_q;
        asm_d   = asm_q;
        frame_d = frame_q;
        fv_d    = 1'b0;
        out_d   = bus.in[s_q];
        if (bus.sync) begin
            // Restart wins over a completion landing on the same edge.
            cnt_d = '0;
            s_d   = 3'd0;
            asm_d = 8'h00;
        end else if (last_dwell) begin
            cnt_d        = '0;
            s_d          = s_q + 3'd1;
            asm_d[s_q]   = bus.in[s_q];
            if (s_q == 3'd7) begin
                frame_d = {bus.in[7], asm_q[6:0]};
                fv_d    = 1'b1;
                asm_d   = 8'h00;
            end
        end else if (bus.en) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            s_q     <= 3'd0;
            out_q   <= 1'b0;
            asm_q   <= 8'h00;
            frame_q <= 8'h00;
            fv_q    <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            out_q   <= out_d;
            asm_q   <= asm_d;
            frame_q <= frame_d;
            fv_q    <= fv_d;
        end
    end

    assign bus.s           = s_q;
    assign bus.out         = out_q;
    assign bus.frame       = frame_q;
    assign bus.frame_valid = fv_q;
endmodule

// File: tb/tb_mux_8x1_scanner.sv
// tb/tb_mux_8x1_scanner.sv - scoreboard bench for the 8:1 scanner at HOLD_CYCLES 4 and 1
module tb_mux_8x1_scanner;
    logic clk = 1'b0;
    logic rst_a, rst_b;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    typedef struct {
        logic [7:0] f;
        int         at;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    mux_8x1_scanner_if bus_a ();
    mux_8x1_scanner_if bus_b ();

    mux_8x1_scanner #(.HOLD_CYCLES(4)) dut_a (.clk(clk), .rst(rst_a), .bus(bus_a.slave));
    mux_8x1_scanner #(.HOLD_CYCLES(1)) dut_b (.clk(clk), .rst(rst_b), .bus(bus_b.slave));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Monitors pop the scoreboard whenever a frame is presented.
    always @(negedge clk) begin
        exp_t e;
        if (bus_a.frame_valid === 1'b1) begin
            if (qa.size() == 0) begin
                chk("a_unexpected_valid", 32'd1, 32'd0);
            end else begin
                e = qa.pop_front();
                chk("a_frame", {24'd0, bus_a.frame}, {24'd0, e.f});
                chk("a_valid_cycle", cyc, e.at);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (bus_b.frame_valid === 1'b1) begin
            if (qb.size() == 0) begin
                chk("b_unexpected_valid", 32'd1, 32'd0);
            end else begin
                e = qb.pop_front();
                chk("b_frame", {24'd0, bus_b.frame}, {24'd0, e.f});
                chk("b_valid_cycle", cyc, e.at);
            end
        end
    end

    initial begin
        int c;
        logic [7:0] out_seq;
        out_seq = 8'b0011_1100;

        rst_a = 1'b1; rst_b = 1'b1;
        bus_a.en = 1'b0; bus_a.sync = 1'b0; bus_a.in = 8'h00;
        bus_b.en = 1'b0; bus_b.sync = 1'b0; bus_b.in = 8'h00;
        tick(); tick();

        chk("rst_s", {29'd0, bus_a.s}, 32'd0);
        chk("rst_out", {31'd0, bus_a.out}, 32'd0);
        chk("rst_frame", {24'd0, bus_a.frame}, 32'd0);
        chk("rst_valid", {31'd0, bus_a.frame_valid}, 32'd0);

        // Constant A5, one sweep; valid 32 edges after release.
        rst_a = 1'b0; bus_a.en = 1'b1; bus_a.in = 8'hA5;
        c = cyc;
        qa.push_back('{f: 8'hA5, at: c + 32});
        for (int n = 0; n <= 32; n++) begin
            chk("t1_s", {29'd0, bus_a.s}, (n / 4) % 8);
            if (n < 32) tick();
        end

        // Lane 2 low except on its last dwell cycle.
        bus_a.sync = 1'b1; bus_a.in = 8'hFF;
        tick();
        bus_a.sync = 1'b0;
        chk("t3_sync_s", {29'd0, bus_a.s}, 32'd0);
        c = cyc;
        qa.push_back('{f: 8'hFF, at: c + 32});
        for (int n = 0; n < 32; n++) begin
            bus_a.in = (n >= 8 && n < 11) ? 8'hFB : 8'hFF;
            tick();
        end
        bus_a.in = 8'hFF;

        // en dropped for 10 cycles while on lane 3.
        bus_a.sync = 1'b1; bus_a.in = 8'h5A;
        tick();
        bus_a.sync = 1'b0;
        c = cyc;
        qa.push_back('{f: 8'h5A, at: c + 42});
        for (int n = 0; n < 32; n++) begin
            if (n == 13) begin
                bus_a.en = 1'b0;
                for (int k = 0; k < 10; k++) begin
                    tick();
                    chk("t4_s_frozen", {29'd0, bus_a.s}, 32'd3);
                end
                bus_a.en = 1'b1;
            end
            tick();
        end

        // sync on lane 7 last dwell suppresses the completion.
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0; bus_a.in = 8'h81;
        repeat (31) tick();
        bus_a.sync = 1'b1;
        tick();
        bus_a.sync = 1'b0;
        chk("t5_s", {29'd0, bus_a.s}, 32'd0);
        chk("t5_frame_kept", {24'd0, bus_a.frame}, 32'h00);
        chk("t5_valid", {31'd0, bus_a.frame_valid}, 32'd0);
        c = cyc;
        qa.push_back('{f: 8'h81, at: c + 32});
        repeat (32) tick();

        // Reset mid-sweep at lane 5.
        repeat (20) tick();
        chk("t6_pre_s", {29'd0, bus_a.s}, 32'd5);
        rst_a = 1'b1;
        tick();
        chk("t6_s", {29'd0, bus_a.s}, 32'd0);
        chk("t6_out", {31'd0, bus_a.out}, 32'd0);
        chk("t6_frame", {24'd0, bus_a.frame}, 32'h00);
        chk("t6_valid", {31'd0, bus_a.frame_valid}, 32'd0);
        rst_a = 1'b0;
        c = cyc;
        qa.push_back('{f: 8'h81, at: c + 32});
        repeat (32) tick();
        bus_a.en = 1'b0;

        // HOLD_CYCLES=1: select every cycle, out lags s by one.
        rst_b = 1'b0; bus_b.en = 1'b1; bus_b.in = 8'h3C;
        c = cyc;
        qb.push_back('{f: 8'h3C, at: c + 8});
        qb.push_back('{f: 8'h3C, at: c + 16});
        for (int n = 0; n <= 16; n++) begin
            chk("t2_s", {29'd0, bus_b.s}, n % 8);
            if (n == 0) chk("t2_out", {31'd0, bus_b.out}, 32'd0);
            else        chk("t2_out", {31'd0, bus_b.out}, {31'd0, out_seq[(n - 1) % 8]});
            if (n < 16) tick();
        end
        bus_b.en = 1'b0;

        repeat (3) tick();
        chk("a_queue_drained", qa.size(), 32'd0);
        chk("b_queue_drained", qb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
